pos_uart_tx: RTL

POS_UART_TX -- requirements
Module: pos_uart_tx

---
 rtl/pos_link_pkg.sv | 33 +++
 rtl/uart_byte_tx.sv | 105 ++++++++++
 rtl/pos_uart_tx.sv | 119 +++++++++++
 3 files changed

// File: rtl/pos_link_pkg.sv
// Shared definitions for the position link (transmitter and receiver sides).
// Latency: n/a (constants, types and a pure function only).
// Backpressure: n/a.
package pos_link_pkg;

  // Frame sync byte sent first in every frame.
  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Frame lengths in bytes: header + X hi/lo + Y hi/lo, optionally + checksum.
  localparam int FRAME_LEN_BASE = 5;
  localparam int FRAME_LEN_CSUM = 6;

  // Coordinates carried on the link and as presented by the game logic.
  localparam int COORD_W     = 10;
  localparam int RAW_COORD_W = 12;

  // Byte serializer line states.
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  // Clamp a raw coordinate into the link range; anything above the max pins to all ones.
  function automatic logic [COORD_W-1:0] sat_coord(input logic [RAW_COORD_W-1:0] raw);
    if (|raw[RAW_COORD_W-1:COORD_W]) begin
      return '1;
    end
    return raw[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB first, one stop bit, CLK_DIV cycles per bit.
// Latency: tx shows the start bit the cycle after start && ready is sampled.
// Backpressure: ready is high in IDLE and on the last stop-bit cycle, so a waiting byte follows with no gap.
module uart_byte_tx
  import pos_link_pkg::*;
#(
  parameter int CLK_DIV = 564
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int                BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  uart_state_t       state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_cnt, bit_n;
  logic [7:0]        shreg, shreg_n;
  logic              tx_n;
  logic              bit_end;

  assign bit_end = (baud_cnt == BAUD_LAST);

  // State register; tx is registered so the line never glitches between bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  // Next-state, bit timing and handshake decode.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + BAUD_W'(1);
    bit_n   = bit_cnt;
    shreg_n = shreg;
    ready   = 1'b0;
    case (state)
      IDLE: begin
        ready  = 1'b1;
        baud_n = '0;
        if (start) begin
          state_n = START;
          shreg_n = data;
        end
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_n = bit_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          ready  = 1'b1;
          baud_n = '0;
          if (start) begin
            state_n = START;
            shreg_n = data;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
      end
    endcase

    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      default: tx_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/pos_uart_tx.sv
// Sends one framed tank position (header, X hi/lo, Y hi/lo [, checksum]) over UART per vsync rising edge.
// Latency: start bit of the header appears the cycle after the edge is detected; busy rises with it.
// Backpressure: edges seen while busy are dropped; optional checksum byte enabled by POS_TX_CHECKSUM_EN.
module pos_uart_tx
  import pos_link_pkg::*;
#(
  parameter int         CLK_DIV = 564,
  parameter logic [7:0] HEADER  = HEADER_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vsync,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic        tx,
  output logic        busy,
  output logic        frame_done
);

`ifdef POS_TX_CHECKSUM_EN
  localparam logic [2:0] FRAME_LEN = 3'(FRAME_LEN_CSUM);
`else
  localparam logic [2:0] FRAME_LEN = 3'(FRAME_LEN_BASE);
`endif

  logic               vsync_q;
  logic               rise;
  logic               fire;
  logic [COORD_W-1:0] x_lat, y_lat;
  logic [2:0]         byte_idx;
  logic [7:0]         x_hi, x_lo, y_hi, y_lo;
  logic [7:0]         byte_dat;
  logic               ser_start;
  logic [7:0]         ser_data;
  logic               ser_ready;
  logic               frame_end;

  assign rise = vsync & ~vsync_q;
  assign fire = rise & ~busy;

  assign x_hi = {{(16 - COORD_W){1'b0}}, x_lat[COORD_W-1:8]};
  assign x_lo = x_lat[7:0];
  assign y_hi = {{(16 - COORD_W){1'b0}}, y_lat[COORD_W-1:8]};
  assign y_lo = y_lat[7:0];

  // Payload byte selected by the index of the next byte to send.
  always_comb begin
    byte_dat = HEADER;
    case (byte_idx)
      3'd1:    byte_dat = x_hi;
      3'd2:    byte_dat = x_lo;
      3'd3:    byte_dat = y_hi;
      3'd4:    byte_dat = y_lo;
`ifdef POS_TX_CHECKSUM_EN
      3'd5:    byte_dat = x_hi ^ x_lo ^ y_hi ^ y_lo;
`endif
      default: byte_dat = HEADER;
    endcase
  end

  // Feed the serializer: header straight from the trigger, then each payload byte as it frees up.
  always_comb begin
    ser_start = 1'b0;
    ser_data  = HEADER;
    if (fire) begin
      ser_start = 1'b1;
    end else if (busy && ser_ready && (byte_idx != FRAME_LEN)) begin
      ser_start = 1'b1;
      ser_data  = byte_dat;
    end
  end

  assign frame_end = busy && ser_ready && (byte_idx == FRAME_LEN);

  // vsync edge register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q <= 1'b0;
    end else begin
      vsync_q <= vsync;
    end
  end

  // Frame sequencer: coordinate latch, byte index, busy and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      byte_idx   <= '0;
      x_lat      <= '0;
      y_lat      <= '0;
    end else begin
      frame_done <= frame_end;
      if (fire) begin
        busy     <= 1'b1;
        byte_idx <= 3'd1;
        x_lat    <= sat_coord(xpos);
        y_lat    <= sat_coord(ypos);
      end else if (ser_start) begin
        byte_idx <= byte_idx + 3'd1;
      end else if (frame_end) begin
        busy     <= 1'b0;
        byte_idx <= '0;
      end
    end
  end

  uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) u_byte_tx (
    .clk  (clk),
    .rst  (rst),
    .start(ser_start),
    .data (ser_data),
    .ready(ser_ready),
    .tx   (tx)
  );

endmodule
